// File: rtl/instruction_loader_pkg.sv
// Shared CPU definitions used by the instruction loader: loader FSM encoding,
// the word size, and the big-endian byte lane selector.
package instruction_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } load_state_t;

    // Byte 0 is the most significant byte of the word (big-endian memory image).
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        b = '0;
        case (idx)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Word stream from the load source plus the byte-wide write port into
// instruction memory, as seen by the loader (slave) and its environment (master).
interface instruction_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/instruction_loader.sv
// Loads a stream of 32-bit instruction words into byte-wide instruction memory,
// one byte per cycle, then releases the CPU pipeline when the session is clean.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 48,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    instruction_loader_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_run,
    output logic                  overflow
);

    // Highest pointer at which a whole word still fits in memory.
    localparam logic [ADDR_W-1:0] LAST_WORD_PTR = ADDR_W'(DEPTH_BYTES - WORD_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP     = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] BYTE_STEP     = ADDR_W'(1);

    load_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word_q;
    logic              last_q;
    logic [1:0]        byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            word_q        <= '0;
            last_q        <= 1'b0;
            byte_cnt      <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cpu_run       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        state        <= ACCEPT;
                        ptr          <= '0;
                        done         <= 1'b0;
                        overflow     <= 1'b0;
                        cpu_run      <= 1'b0;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end

                ACCEPT: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (ptr <= LAST_WORD_PTR) begin
                            // First byte goes out on the cycle right after the handshake.
                            state         <= WRITE;
                            word_q        <= bus.in_data;
                            last_q        <= bus.in_last;
                            byte_cnt      <= '0;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= ptr;
                            bus.mem_wdata <= word_byte(bus.in_data, 2'd0);
                        end else begin
                            state    <= DONE;
                            overflow <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_run  <= 1'b0;
                        end
                    end
                end

                WRITE: begin
                    if (byte_cnt == 2'd3) begin
                        bus.mem_we <= 1'b0;
                        ptr        <= ptr + WORD_STEP;
                        if (last_q) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cpu_run <= ~overflow;
                        end else begin
                            state        <= ACCEPT;
                            bus.in_ready <= 1'b1;
                        end
                    end else begin
                        byte_cnt      <= byte_cnt + 2'd1;
                        bus.mem_addr  <= bus.mem_addr + BYTE_STEP;
                        bus.mem_wdata <= word_byte(word_q, byte_cnt + 2'd1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader (DEPTH_BYTES=48).
module tb_instruction_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic load_start = 1'b0;
    logic busy, done, cpu_run, overflow;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    instruction_loader_if #(.ADDR_W(32)) bus ();

    instruction_loader #(.DEPTH_BYTES(48), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .cpu_run    (cpu_run),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Write log, handshake cycle log and in_ready cycle count.
    logic [31:0] log_addr[$];
    logic [7:0]  log_data[$];
    int unsigned hs_cyc[$];
    int unsigned cyc = 0;
    int unsigned ready_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we === 1'b1) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) hs_cyc.push_back(cyc);
        if (bus.in_ready === 1'b1) ready_cnt <= ready_cnt + 1;
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int unsigned k);
        logic [31:0] s;
        s = w >> (8 * (3 - k));
        return s[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        hs_cyc.delete();
        ready_cnt = 0;
    endtask

    // Presents a word and returns just after its handshake edge (first WRITE cycle).
    task automatic send_word(input logic [31:0] w, input logic last);
        int unsigned waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_wait: in_ready=%b required 1 within 50 cycles", bus.in_ready);
        end
        tick();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.mem_we, busy, done, cpu_run, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/we/busy/done/run/ovf=%b required 000000",
                     {bus.in_ready, bus.mem_we, busy, done, cpu_run, overflow});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_autostart: busy=%b in_ready=%b required 0 0", busy, bus.in_ready);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        w = 32'h8C10_0000;
        pulse_load();
        n_cmp++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_entry: busy=%b in_ready=%b done=%b required 1 1 0", busy, bus.in_ready, done);
        end
        send_word(w, 1'b1);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_write: in_ready=%b required 0", bus.in_ready);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            n_cmp++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'(k) || bus.mem_wdata !== exp_byte(w, k)) begin
                n_fail++;
                $display("FAIL single_byte%0d: we=%b addr=%0d data=%h required 1 %0d %h",
                         k, bus.mem_we, bus.mem_addr, bus.mem_wdata, k, exp_byte(w, k));
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || busy !== 1'b0 || bus.mem_we !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b run=%b busy=%b we=%b ovf=%b required 1 1 0 0 0",
                     done, cpu_run, busy, bus.mem_we, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[12];
        for (int i = 0; i < 12; i++) words[i] = {8'(i + 1), 8'hA5, 8'(8'hF0 - i), 8'h3C};
        pulse_load();
        clear_logs();
        for (int i = 0; i < 12; i++) send_word(words[i], (i == 11));
        bus.in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (log_addr.size() != 48) begin
            n_fail++;
            $display("FAIL b2b_write_count: got %0d required 48", log_addr.size());
        end else begin
            for (int j = 0; j < 48; j++) begin
                n_cmp++;
                if (log_addr[j] !== 32'(j) || log_data[j] !== exp_byte(words[j / 4], j % 4)) begin
                    n_fail++;
                    $display("FAIL b2b_write%0d: addr=%0d data=%h required %0d %h",
                             j, log_addr[j], log_data[j], j, exp_byte(words[j / 4], j % 4));
                end
            end
        end
        n_cmp++;
        if (hs_cyc.size() != 12) begin
            n_fail++;
            $display("FAIL b2b_handshakes: got %0d required 12", hs_cyc.size());
        end else begin
            for (int i = 1; i < 12; i++) begin
                n_cmp++;
                if (hs_cyc[i] - hs_cyc[i - 1] != 5) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles required 5", i, hs_cyc[i] - hs_cyc[i - 1]);
                end
            end
        end
        n_cmp++;
        if (ready_cnt != 12) begin
            n_fail++;
            $display("FAIL b2b_ready_cycles: got %0d required 12", ready_cnt);
        end
        n_cmp++;
        if (done !== 1'b1 || overflow !== 1'b0 || cpu_run !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b ovf=%b run=%b required 1 0 1", done, overflow, cpu_run);
        end
    endtask

    task automatic test_overflow();
        pulse_load();
        clear_logs();
        for (int i = 0; i < 13; i++) send_word(32'h1111_1111 * (i + 1), 1'b0);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || overflow !== 1'b1 || cpu_run !== 1'b0 || busy !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_state: done=%b ovf=%b run=%b busy=%b we=%b required 1 1 0 0 0",
                     done, overflow, cpu_run, busy, bus.mem_we);
        end
        tick();
        n_cmp++;
        if (log_addr.size() != 48 || log_addr[log_addr.size() - 1] !== 32'd47) begin
            n_fail++;
            $display("FAIL overflow_dropped: writes=%0d required 48 ending at 47", log_addr.size());
        end
        n_cmp++;
        if (overflow !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: ovf=%b done=%b required 1 1", overflow, done);
        end
    endtask

    task automatic test_load_start_mid();
        pulse_load();
        n_cmp++;
        if (done !== 1'b0 || overflow !== 1'b0 || cpu_run !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: done=%b ovf=%b run=%b busy=%b required 0 0 0 1",
                     done, overflow, cpu_run, busy);
        end
        clear_logs();
        send_word(32'hDEAD_BEEF, 1'b0);
        bus.in_valid = 1'b0;
        load_start = 1'b1;
        repeat (2) tick();
        load_start = 1'b0;
        send_word(32'h0102_0304, 1'b1);
        bus.in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (log_addr.size() != 8) begin
            n_fail++;
            $display("FAIL midstart_count: got %0d required 8", log_addr.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_cmp++;
                if (log_addr[j] !== 32'(j)) begin
                    n_fail++;
                    $display("FAIL midstart_addr%0d: got %0d required %0d", j, log_addr[j], j);
                end
            end
            n_cmp++;
            if (log_data[4] !== 8'h01 || log_data[3] !== 8'hEF) begin
                n_fail++;
                $display("FAIL midstart_data: byte3=%h byte4=%h required EF 01", log_data[3], log_data[4]);
            end
        end
        n_cmp++;
        if (done !== 1'b1 || cpu_run !== 1'b1) begin
            n_fail++;
            $display("FAIL midstart_done: done=%b run=%b required 1 1", done, cpu_run);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        pulse_load();
        clear_logs();
        send_word(32'hAAAA_0001, 1'b0);
        send_word(32'hBBBB_0002, 1'b0);
        send_word(32'hCCDD_EEFF, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.mem_addr !== 32'd9 || bus.mem_wdata !== 8'hDD) begin
            n_fail++;
            $display("FAIL pre_reset_byte: addr=%0d data=%h required 9 DD", bus.mem_addr, bus.mem_wdata);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.mem_we, busy, done, cpu_run, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready/we/busy/done/run/ovf=%b required 000000",
                     {bus.in_ready, bus.mem_we, busy, done, cpu_run, overflow});
        end
        tick();
        n_cmp++;
        if (log_addr.size() != 9 || log_addr[log_addr.size() - 1] !== 32'd8) begin
            n_fail++;
            $display("FAIL midreset_partial: writes=%0d required 9 ending at 8", log_addr.size());
        end
        rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: busy=%b required 0", busy);
        end
        w = 32'h1357_9BDF;
        pulse_load();
        clear_logs();
        send_word(w, 1'b1);
        bus.in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (log_addr.size() != 4) begin
            n_fail++;
            $display("FAIL rewrite_count: got %0d required 4", log_addr.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                n_cmp++;
                if (log_addr[j] !== 32'(j) || log_data[j] !== exp_byte(w, j)) begin
                    n_fail++;
                    $display("FAIL rewrite%0d: addr=%0d data=%h required %0d %h",
                             j, log_addr[j], log_data[j], j, exp_byte(w, j));
                end
            end
        end
    endtask

    task automatic test_idle_valid();
        pulse_load();
        clear_logs();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: busy=%b ready=%b we=%b required 1 1 0", i, busy, bus.in_ready, bus.mem_we);
            end
            tick();
        end
        send_word(32'h7766_5544, 1'b1);
        bus.in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (log_addr.size() != 4 || log_addr[0] !== 32'd0 || log_data[0] !== 8'h77 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume: writes=%0d done=%b required 4 writes from addr 0 and done 1",
                     log_addr.size(), done);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_load_start_mid();
        test_reset_mid();
        test_idle_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
